// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: counter encodings, PC step
// and the 2-bit saturating counter update.
package bp_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam logic [1:0] CTR_RESET = WNT;
   localparam logic [1:0] CTR_ALLOC = WT;

   localparam int unsigned PC_INC = 4;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken && ctr != ST) res = ctr + 2'd1;
      else if (!taken && ctr != SNT) res = ctr - 2'd1;
      return res;
   endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped BTB storage: two combinational read ports (fetch, EX) and
// one synchronous write port. Reset clears valid bits and parks counters at WNT.
module bp_btb
   import bp_pkg::*;
#(
   parameter int unsigned PCLEN    = 32,
   parameter int unsigned ENTRIES  = 16,
   parameter int unsigned IDX_BITS = $clog2(ENTRIES),
   parameter int unsigned TAG_BITS = PCLEN - IDX_BITS - 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] rd_idx_a_i,
   output logic                rd_valid_a_o,
   output logic [TAG_BITS-1:0] rd_tag_a_o,
   output logic [PCLEN-1:0]    rd_target_a_o,
   output logic [1:0]          rd_ctr_a_o,
   input  logic [IDX_BITS-1:0] rd_idx_b_i,
   output logic                rd_valid_b_o,
   output logic [TAG_BITS-1:0] rd_tag_b_o,
   output logic [PCLEN-1:0]    rd_target_b_o,
   output logic [1:0]          rd_ctr_b_o,
   input  logic                wr_en_i,
   input  logic [IDX_BITS-1:0] wr_idx_i,
   input  logic [TAG_BITS-1:0] wr_tag_i,
   input  logic [PCLEN-1:0]    wr_target_i,
   input  logic [1:0]          wr_ctr_i
);

   logic                valid_q  [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [PCLEN-1:0]    target_q [ENTRIES];

   assign rd_valid_a_o  = valid_q[rd_idx_a_i];
   assign rd_tag_a_o    = tag_q[rd_idx_a_i];
   assign rd_target_a_o = target_q[rd_idx_a_i];
   assign rd_ctr_a_o    = ctr_q[rd_idx_a_i];

   assign rd_valid_b_o  = valid_q[rd_idx_b_i];
   assign rd_tag_b_o    = tag_q[rd_idx_b_i];
   assign rd_target_b_o = target_q[rd_idx_b_i];
   assign rd_ctr_b_o    = ctr_q[rd_idx_b_i];

   // Reset takes priority over a write issued in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_RESET;
         end
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= 1'b1;
         ctr_q[wr_idx_i]   <= wr_ctr_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_en_i) begin
         tag_q[wr_idx_i]    <= wr_tag_i;
         target_q[wr_idx_i] <= wr_target_i;
      end
   end

endmodule

// File: rtl/branch_pred_unit.sv
// Fetch-side branch predictor: BTB lookup drives the next fetch PC, EX-stage
// resolution raises redirects and trains the table. Optional BPU_STATS_EN adds counters.
module branch_pred_unit
   import bp_pkg::*;
#(
   parameter int unsigned PCLEN       = 32,
   parameter int unsigned BTB_ENTRIES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PCLEN-1:0] F_pc_va,
   output logic [PCLEN-1:0] F_BP_target_pc,
   output logic             F_BP_taken,
   input  logic             EX_valid,
   input  logic             EX_is_branch,
   input  logic [PCLEN-1:0] EX_pc,
   input  logic             EX_pred_taken,
   input  logic [PCLEN-1:0] EX_pred_target,
   input  logic             EX_br_taken,
   input  logic [PCLEN-1:0] EX_br_target,
   output logic             EX_taken,
   output logic [PCLEN-1:0] EX_alt_pc
`ifdef BPU_STATS_EN
   ,
   output logic [31:0]      stat_branches,
   output logic [31:0]      stat_mispred
`endif
);

   localparam int unsigned IDX_BITS = $clog2(BTB_ENTRIES);
   localparam int unsigned TAG_BITS = PCLEN - IDX_BITS - 2;

   logic [IDX_BITS-1:0] f_idx, ex_idx;
   logic [TAG_BITS-1:0] f_tag, ex_tag;
   logic                f_valid, ex_valid_e;
   logic [TAG_BITS-1:0] f_etag, ex_etag;
   logic [PCLEN-1:0]    f_target, ex_target;
   logic [1:0]          f_ctr, ex_ctr;
   logic                f_hit, ex_hit;
   logic                wr_en;
   logic [PCLEN-1:0]    wr_target;
   logic [1:0]          wr_ctr;
   logic [PCLEN-1:0]    ex_seq_pc;

   assign f_idx  = F_pc_va[IDX_BITS+1:2];
   assign f_tag  = F_pc_va[PCLEN-1:IDX_BITS+2];
   assign ex_idx = EX_pc[IDX_BITS+1:2];
   assign ex_tag = EX_pc[PCLEN-1:IDX_BITS+2];

   bp_btb #(
      .PCLEN   (PCLEN),
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk           (clk),
      .rst           (rst),
      .rd_idx_a_i    (f_idx),
      .rd_valid_a_o  (f_valid),
      .rd_tag_a_o    (f_etag),
      .rd_target_a_o (f_target),
      .rd_ctr_a_o    (f_ctr),
      .rd_idx_b_i    (ex_idx),
      .rd_valid_b_o  (ex_valid_e),
      .rd_tag_b_o    (ex_etag),
      .rd_target_b_o (ex_target),
      .rd_ctr_b_o    (ex_ctr),
      .wr_en_i       (wr_en),
      .wr_idx_i      (ex_idx),
      .wr_tag_i      (ex_tag),
      .wr_target_i   (wr_target),
      .wr_ctr_i      (wr_ctr)
   );

   assign f_hit  = f_valid && (f_etag == f_tag);
   assign ex_hit = ex_valid_e && (ex_etag == ex_tag);

   always_comb begin
      F_BP_taken     = f_hit && (f_ctr >= WT);
      F_BP_target_pc = F_BP_taken ? f_target : F_pc_va + PCLEN'(PC_INC);
   end

   assign ex_seq_pc = EX_pc + PCLEN'(PC_INC);

   // A non-branch predicted taken is a BTB alias and must fall through.
   always_comb begin
      EX_taken  = 1'b0;
      EX_alt_pc = ex_seq_pc;
      if (EX_valid) begin
         if (EX_is_branch) begin
            if ((EX_br_taken != EX_pred_taken) ||
                (EX_br_taken && (EX_br_target != EX_pred_target))) begin
               EX_taken  = 1'b1;
               EX_alt_pc = EX_br_taken ? EX_br_target : ex_seq_pc;
            end
         end else if (EX_pred_taken) begin
            EX_taken = 1'b1;
         end
      end
   end

   always_comb begin
      wr_en     = 1'b0;
      wr_target = ex_target;
      wr_ctr    = ex_ctr;
      if (EX_valid && EX_is_branch) begin
         if (ex_hit) begin
            wr_en  = 1'b1;
            wr_ctr = sat_update(ex_ctr, EX_br_taken);
            if (EX_br_taken) wr_target = EX_br_target;
         end else if (EX_br_taken) begin
            wr_en     = 1'b1;
            wr_target = EX_br_target;
            wr_ctr    = CTR_ALLOC;
         end
      end else if (EX_valid && EX_pred_taken && ex_hit) begin
         wr_en  = 1'b1;
         wr_ctr = sat_update(ex_ctr, 1'b0);
      end
   end

`ifdef BPU_STATS_EN
   logic [31:0] stat_branches_q, stat_mispred_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches_q <= '0;
         stat_mispred_q  <= '0;
      end else begin
         if (EX_valid && EX_is_branch) stat_branches_q <= stat_branches_q + 32'd1;
         if (EX_taken) stat_mispred_q <= stat_mispred_q + 32'd1;
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: directed plan plus randomized
// traffic against a table-level reference model. Honours BPU_STATS_EN.
module tb_branch_pred_unit;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] F_pc_va, F_BP_target_pc;
   logic        F_BP_taken;
   logic        EX_valid, EX_is_branch, EX_pred_taken, EX_br_taken, EX_taken;
   logic [31:0] EX_pc, EX_pred_target, EX_br_target, EX_alt_pc;
`ifdef BPU_STATS_EN
   logic [31:0] stat_branches, stat_mispred;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   bit          m_valid [N];
   logic [31:0] m_tag   [N];
   logic [31:0] m_target[N];
   int          m_ctr   [N];
   logic [31:0] m_branches, m_mispred;

   always #5 clk = ~clk;

   branch_pred_unit #(.PCLEN(32), .BTB_ENTRIES(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .F_pc_va        (F_pc_va),
      .F_BP_target_pc (F_BP_target_pc),
      .F_BP_taken     (F_BP_taken),
      .EX_valid       (EX_valid),
      .EX_is_branch   (EX_is_branch),
      .EX_pc          (EX_pc),
      .EX_pred_taken  (EX_pred_taken),
      .EX_pred_target (EX_pred_target),
      .EX_br_taken    (EX_br_taken),
      .EX_br_target   (EX_br_target),
      .EX_taken       (EX_taken),
      .EX_alt_pc      (EX_alt_pc)
`ifdef BPU_STATS_EN
      ,
      .stat_branches  (stat_branches),
      .stat_mispred   (stat_mispred)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc / 4) % N);
   endfunction

   function automatic logic [31:0] m_tagof(input logic [31:0] pc);
      return pc / (4 * N);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
   endfunction

   task automatic m_lookup(input logic [31:0] pc, output bit tk, output logic [31:0] tgt);
      tk  = m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
      tgt = tk ? m_target[m_idx(pc)] : pc + 32'd4;
   endtask

   task automatic m_resolve(output bit mis, output logic [31:0] alt);
      mis = 0;
      alt = EX_pc + 32'd4;
      if (EX_valid) begin
         if (EX_is_branch)
            mis = (EX_br_taken != EX_pred_taken) || (EX_br_taken && EX_br_target != EX_pred_target);
         else
            mis = EX_pred_taken;
         if (mis && EX_is_branch && EX_br_taken) alt = EX_br_target;
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0;
         m_ctr[i]   = 1;
      end
      m_branches = 0;
      m_mispred  = 0;
   endtask

   // applies one clock edge worth of training with the inputs currently driven
   task automatic m_train();
      bit mis;
      logic [31:0] alt;
      int i;
      i = m_idx(EX_pc);
      if (rst) begin
         m_reset();
         return;
      end
      m_resolve(mis, alt);
      if (EX_valid && EX_is_branch) m_branches++;
      if (mis) m_mispred++;
      if (EX_valid && EX_is_branch) begin
         if (m_hit(EX_pc)) begin
            if (EX_br_taken) begin
               m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
               m_target[i] = EX_br_target;
            end else begin
               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
         end else if (EX_br_taken) begin
            m_valid[i]  = 1;
            m_tag[i]    = m_tagof(EX_pc);
            m_target[i] = EX_br_target;
            m_ctr[i]    = 2;
         end
      end else if (EX_valid && EX_pred_taken && m_hit(EX_pc)) begin
         m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
   endtask

   // compare every output against the model, then wait past the next edge
   task automatic settle();
      bit tk, mis;
      logic [31:0] tgt, alt;
      #1;
      m_lookup(F_pc_va, tk, tgt);
      m_resolve(mis, alt);
      check_val("f_taken", {31'd0, F_BP_taken}, {31'd0, tk});
      check_val("f_target", F_BP_target_pc, tgt);
      check_val("ex_taken", {31'd0, EX_taken}, {31'd0, mis});
      check_val("ex_alt_pc", EX_alt_pc, alt);
`ifdef BPU_STATS_EN
      check_val("stat_branches", stat_branches, m_branches);
      check_val("stat_mispred", stat_mispred, m_mispred);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      m_train();
      @(negedge clk);
   endtask

   task automatic drive_ex(input bit v, input bit br, input logic [31:0] pc, input bit pt,
                           input logic [31:0] ptgt, input bit bt, input logic [31:0] btgt);
      EX_valid       = v;
      EX_is_branch   = br;
      EX_pc          = pc;
      EX_pred_taken  = pt;
      EX_pred_target = ptgt;
      EX_br_taken    = bt;
      EX_br_target   = btgt;
   endtask

   // branch at pc resolving to bt/btgt, carrying whatever fetch predicted for it
   task automatic resolve_branch(input logic [31:0] pc, input bit bt, input logic [31:0] btgt);
      bit tk;
      logic [31:0] tgt;
      m_lookup(pc, tk, tgt);
      drive_ex(1, 1, pc, tk, tgt, bt, btgt);
      settle();
      tick();
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] pc;
      pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
      return pc;
   endfunction

   initial begin
      rst     = 1'b1;
      F_pc_va = 32'h100;
      drive_ex(0, 0, 0, 0, 0, 0, 0);
      m_reset();
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;

      // reset state
      settle();
      check_val("reset_f_taken", {31'd0, F_BP_taken}, 32'd0);
      check_val("reset_f_target", F_BP_target_pc, 32'h104);
      check_val("reset_ex_taken", {31'd0, EX_taken}, 32'd0);
      tick();

      // first taken resolution allocates the entry
      drive_ex(1, 1, 32'h100, 0, 32'h104, 1, 32'h200);
      settle();
      check_val("alloc_ex_taken", {31'd0, EX_taken}, 32'd1);
      check_val("alloc_alt_pc", EX_alt_pc, 32'h200);
      tick();
      drive_ex(0, 0, 0, 0, 0, 0, 0);
      settle();
      check_val("alloc_f_taken", {31'd0, F_BP_taken}, 32'd1);
      check_val("alloc_f_target", F_BP_target_pc, 32'h200);
      tick();

      // two not-taken resolutions, each carrying a taken prediction
      drive_ex(1, 1, 32'h100, 1, 32'h200, 0, 32'h0);
      settle();
      check_val("nt1_ex_taken", {31'd0, EX_taken}, 32'd1);
      check_val("nt1_alt_pc", EX_alt_pc, 32'h104);
      tick();
      settle();
      check_val("nt1_f_taken", {31'd0, F_BP_taken}, 32'd0);
      check_val("nt1_f_target", F_BP_target_pc, 32'h104);
      check_val("nt2_alt_pc", EX_alt_pc, 32'h104);
      tick();

      // saturate at strongly taken, one not-taken keeps predicting taken
      for (int i = 0; i < 4; i++) resolve_branch(32'h100, 1, 32'h200);
      resolve_branch(32'h100, 0, 32'h0);
      drive_ex(0, 0, 0, 0, 0, 0, 0);
      settle();
      check_val("sat_f_taken", {31'd0, F_BP_taken}, 32'd1);
      tick();

      // tag alias and non-branch alias redirect
      F_pc_va = 32'h1100;
      drive_ex(1, 0, 32'h300, 1, 32'h200, 0, 32'h0);
      settle();
      check_val("alias_f_taken", {31'd0, F_BP_taken}, 32'd0);
      check_val("alias_f_target", F_BP_target_pc, 32'h1104);
      check_val("alias_ex_taken", {31'd0, EX_taken}, 32'd1);
      check_val("alias_alt_pc", EX_alt_pc, 32'h304);
      tick();

      // same-cycle lookup and update on index 0: 10 -> 01
      F_pc_va = 32'h100;
      drive_ex(1, 1, 32'h100, 1, 32'h200, 0, 32'h0);
      settle();
      check_val("rw_old_taken", {31'd0, F_BP_taken}, 32'd1);
      tick();
      drive_ex(0, 0, 0, 0, 0, 0, 0);
      settle();
      check_val("rw_new_taken", {31'd0, F_BP_taken}, 32'd0);
      tick();

      // PC wrap at the top of the address space
      F_pc_va = 32'hFFFF_FFFC;
      settle();
      check_val("wrap_f_target", F_BP_target_pc, 32'h0);
      tick();

`ifdef BPU_STATS_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      resolve_branch(32'h140, 0, 32'h0);
      resolve_branch(32'h180, 1, 32'h400);
      resolve_branch(32'h1C0, 0, 32'h0);
      drive_ex(0, 0, 0, 0, 0, 0, 0);
      settle();
      check_val("stats_branches3", stat_branches, 32'd3);
      check_val("stats_mispred1", stat_mispred, 32'd1);
      tick();
`endif

      // randomized traffic, including occasional reset during updates
      for (int n = 0; n < 600; n++) begin
         bit tk;
         logic [31:0] tgt, pc;
         rst     = ($urandom_range(0, 59) == 0);
         F_pc_va = rand_pc();
         pc      = rand_pc();
         m_lookup(pc, tk, tgt);
         if ($urandom_range(0, 3) == 0) begin
            tk  = $urandom_range(0, 1);
            tgt = rand_pc();
         end
         drive_ex($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, pc, tk, tgt,
                  $urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? rand_pc() : 32'h200);
         settle();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
